read_arbiter: RTL

Per-output-port read scheduler for the shared-SRAM switch buffer, the read-side counterpart of the write arbitration path. It watches the eight priority queues (3-bit priority) of one output port, picks the next queue to dequeue by strict priority (SP) or weighted round robin (WRR), and hands it to the read engine with a valid/ready handshake. The grant is held for a whole packet and released on the read engine's end-of-packet pulse.

---
 rtl/read_arbiter_if.sv | 27 ++
 rtl/read_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/read_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : read_arbiter_if
// Description : Request/completion handshake between read scheduler and read engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface read_arbiter_if;
  logic       rd_valid;
  logic [2:0] rd_queue;
  logic       rd_ready;
  logic       pkt_done;

  modport master (
    output rd_valid,
    output rd_queue,
    input  rd_ready,
    input  pkt_done
  );

  modport slave (
    input  rd_valid,
    input  rd_queue,
    output rd_ready,
    output pkt_done
  );
endinterface
`default_nettype wire

// File: rtl/read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : read_arbiter
// Description : Per-output-port SP/WRR queue scheduler, grant held per packet.
// Revision    : 1.0 - initial release
// ============================================================================
module read_arbiter #(
  parameter int NUM_OF_QUEUES = 8,
  parameter int WEIGHT_WIDTH  = 4
) (
  input  wire logic                                  clk,
  input  wire logic                                  rst_n,
  input  wire logic                                  sp0_wrr1,
  input  wire logic [NUM_OF_QUEUES-1:0]              queue_nonempty,
  input  wire logic [NUM_OF_QUEUES*WEIGHT_WIDTH-1:0] weight_in,
  output logic                                       busy,
  read_arbiter_if.master                             rd_if
);

  localparam int c_IDX_W = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_READING = 2'd2
  } state_t;

  state_t                                    r_state, w_state_nxt;
  logic                                      r_rd_valid, w_rd_valid_nxt;
  logic [c_IDX_W-1:0]                        r_rd_queue, w_rd_queue_nxt;
  logic [c_IDX_W-1:0]                        r_rr_ptr, w_rr_ptr_nxt;
  logic [NUM_OF_QUEUES-1:0][WEIGHT_WIDTH-1:0] r_credit, w_credit_nxt;
  logic [NUM_OF_QUEUES-1:0][WEIGHT_WIDTH-1:0] w_weight, w_eff_credit;
  logic [NUM_OF_QUEUES-1:0]                  w_eligible;
  logic                                      w_credit_live;
  logic                                      w_wrr_found;
  logic [c_IDX_W-1:0]                        w_wrr_win, w_sp_win, w_idx;
  logic                                      w_req;

  assign w_weight = weight_in;

  // Reload only when no nonempty queue still has credit; weight 0 counts as 1.
  always_comb begin
    w_credit_live = 1'b0;
    w_eff_credit  = '0;
    w_eligible    = '0;
    for (int q = 0; q < NUM_OF_QUEUES; q++) begin
      if (queue_nonempty[q] && (r_credit[q] != '0)) begin
        w_credit_live = 1'b1;
      end
    end
    for (int q = 0; q < NUM_OF_QUEUES; q++) begin
      if (w_credit_live) begin
        w_eff_credit[q] = r_credit[q];
      end else if (w_weight[q] == '0) begin
        w_eff_credit[q] = WEIGHT_WIDTH'(1);
      end else begin
        w_eff_credit[q] = w_weight[q];
      end
      w_eligible[q] = queue_nonempty[q] && (w_eff_credit[q] != '0);
    end
  end

  always_comb begin
    w_wrr_found = 1'b0;
    w_wrr_win   = '0;
    w_idx       = '0;
    for (int i = 0; i < NUM_OF_QUEUES; i++) begin
      w_idx = r_rr_ptr + c_IDX_W'(i);
      if (!w_wrr_found && w_eligible[w_idx]) begin
        w_wrr_found = 1'b1;
        w_wrr_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_sp_win = '0;
    for (int q = 0; q < NUM_OF_QUEUES; q++) begin
      if (queue_nonempty[q]) begin
        w_sp_win = c_IDX_W'(q);
      end
    end
  end

  assign w_req = sp0_wrr1 ? w_wrr_found : (|queue_nonempty);

  always_comb begin
    w_state_nxt    = r_state;
    w_rd_valid_nxt = r_rd_valid;
    w_rd_queue_nxt = r_rd_queue;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_credit_nxt   = r_credit;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_rd_valid_nxt = 1'b1;
          w_state_nxt    = S_GRANT;
          if (sp0_wrr1) begin
            w_rd_queue_nxt            = w_wrr_win;
            w_credit_nxt              = w_eff_credit;
            w_credit_nxt[w_wrr_win]   = w_eff_credit[w_wrr_win] - WEIGHT_WIDTH'(1);
            if (w_credit_nxt[w_wrr_win] == '0) begin
              w_rr_ptr_nxt = w_wrr_win + c_IDX_W'(1);
            end else begin
              w_rr_ptr_nxt = w_wrr_win;
            end
          end else begin
            w_rd_queue_nxt = w_sp_win;
          end
        end
      end
      S_GRANT: begin
        if (r_rd_valid && rd_if.rd_ready) begin
          w_rd_valid_nxt = 1'b0;
          w_state_nxt    = S_READING;
        end
      end
      S_READING: begin
        if (rd_if.pkt_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_rd_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rd_valid <= 1'b0;
      r_rd_queue <= '0;
      r_rr_ptr   <= '0;
      r_credit   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_rd_queue <= w_rd_queue_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_credit   <= w_credit_nxt;
    end
  end

  assign rd_if.rd_valid = r_rd_valid;
  assign rd_if.rd_queue = r_rd_queue;
  assign busy           = (r_state != S_IDLE);

endmodule
`default_nettype wire
